// File: rtl/tlb_walk_pkg.sv
// Shared types for the ITLB/DTLB page-table-walk arbiter: walk FSM states and walk owner.
package tlb_walk_pkg;

    localparam int VA_BITS_DEFAULT  = 39;
    localparam int PTE_BITS_DEFAULT = 64;

    typedef enum logic [1:0] {
        WALK_IDLE,
        WALK_REQ,
        WALK_WAIT,
        WALK_RESP
    } walkstate_t;

    typedef enum logic {
        OWN_DTLB,
        OWN_ITLB
    } walkowner_t;

endpackage

// File: rtl/tlb_walk_arb_pick.sv
// Combinational grant between ITLB and DTLB misses; RR_EN selects round-robin versus
// fixed DTLB-over-ITLB priority so the walk FSM is the same in both builds.
module tlb_walk_arb_pick
    import tlb_walk_pkg::*;
#(
    parameter bit RR_EN = 1'b0
) (
    input  logic       itlb_miss,
    input  logic       dtlb_miss,
    input  walkowner_t last_owner,
    output logic       grant_valid,
    output walkowner_t grant_owner
);

    // On a tie the DTLB wins unless round-robin says the ITLB is due.
    always_comb begin
        grant_valid = itlb_miss | dtlb_miss;
        grant_owner = OWN_DTLB;
        if (itlb_miss && !dtlb_miss) begin
            grant_owner = OWN_ITLB;
        end else if (itlb_miss && dtlb_miss && RR_EN && (last_owner == OWN_DTLB)) begin
            grant_owner = OWN_ITLB;
        end
    end

endmodule

// File: rtl/tlb_walk_arbiter.sv
// Shares one page-table walker between ITLB and DTLB misses, returning a write or fault pulse.
// Define TLB_WALK_RR_EN for round-robin arbitration; default is fixed DTLB > ITLB priority.
module tlb_walk_arbiter
    import tlb_walk_pkg::*;
#(
    parameter int VA_BITS  = VA_BITS_DEFAULT,
    parameter int PTE_BITS = PTE_BITS_DEFAULT
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                ITLBMiss,
    input  logic [VA_BITS-1:0]  ITLBVAdr,
    input  logic                DTLBMiss,
    input  logic [VA_BITS-1:0]  DTLBVAdr,
    input  logic                TLBFlush,
    output logic                WalkReq,
    output logic [VA_BITS-1:0]  WalkVAdr,
    input  logic                WalkAck,
    input  logic                WalkDone,
    input  logic                WalkFault,
    input  logic [PTE_BITS-1:0] WalkPTE,
    output logic                ITLBWrite,
    output logic                DTLBWrite,
    output logic [PTE_BITS-1:0] TLBPTE,
    output logic                ITLBFault,
    output logic                DTLBFault,
    output logic                Busy
);

    walkstate_t state, state_next;
    walkowner_t owner, last_owner, grant_owner;
    logic       grant_valid;
    logic       drop, drop_next;
    logic       fault_q;
    logic       take_grant, take_result;
    logic       resp_live;

`ifdef TLB_WALK_RR_EN
    localparam bit RR_EN = 1'b1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_owner <= OWN_ITLB;
        end else if (take_grant) begin
            last_owner <= grant_owner;
        end
    end
`else
    localparam bit RR_EN = 1'b0;

    assign last_owner = OWN_DTLB;
`endif

    tlb_walk_arb_pick #(
        .RR_EN (RR_EN)
    ) u_pick (
        .itlb_miss   (ITLBMiss),
        .dtlb_miss   (DTLBMiss),
        .last_owner  (last_owner),
        .grant_valid (grant_valid),
        .grant_owner (grant_owner)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= WALK_IDLE;
            drop  <= 1'b0;
        end else begin
            state <= state_next;
            drop  <= drop_next;
        end
    end

    // An ack coinciding with a flush still commits the walker, so the walk is tracked and dropped.
    always_comb begin
        state_next  = state;
        drop_next   = drop;
        take_grant  = 1'b0;
        take_result = 1'b0;
        case (state)
            WALK_IDLE: begin
                if (grant_valid && !TLBFlush) begin
                    take_grant = 1'b1;
                    state_next = WALK_REQ;
                end
            end
            WALK_REQ: begin
                if (WalkAck) begin
                    state_next = WALK_WAIT;
                    drop_next  = TLBFlush;
                end else if (TLBFlush) begin
                    state_next = WALK_IDLE;
                end
            end
            WALK_WAIT: begin
                if (TLBFlush) begin
                    drop_next = 1'b1;
                end
                if (WalkDone) begin
                    take_result = 1'b1;
                    state_next  = WALK_RESP;
                end
            end
            WALK_RESP: begin
                state_next = WALK_IDLE;
            end
            default: begin
                state_next = WALK_IDLE;
            end
        endcase
        if (state_next == WALK_IDLE) begin
            drop_next = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            owner    <= OWN_DTLB;
            WalkVAdr <= '0;
        end else if (take_grant) begin
            owner    <= grant_owner;
            WalkVAdr <= (grant_owner == OWN_ITLB) ? ITLBVAdr : DTLBVAdr;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            TLBPTE  <= '0;
            fault_q <= 1'b0;
        end else if (take_result) begin
            TLBPTE  <= WalkPTE;
            fault_q <= WalkFault;
        end
    end

    // A flush landing in the response cycle itself also suppresses the strobe.
    assign resp_live = (state == WALK_RESP) && !drop && !TLBFlush;
    assign ITLBWrite = resp_live && (owner == OWN_ITLB) && !fault_q;
    assign DTLBWrite = resp_live && (owner == OWN_DTLB) && !fault_q;
    assign ITLBFault = resp_live && (owner == OWN_ITLB) && fault_q;
    assign DTLBFault = resp_live && (owner == OWN_DTLB) && fault_q;
    assign WalkReq   = (state == WALK_REQ);
    assign Busy      = (state != WALK_IDLE);

endmodule

// File: tb/tb_tlb_walk_arbiter.sv
// Self-checking bench for tlb_walk_arbiter: directed walk scenarios with literal expectations,
// then randomized misses/flushes/walker timing against a transaction-level reference model.
module tb_tlb_walk_arbiter;

    localparam int VA  = 39;
    localparam int PTE = 64;
`ifdef TLB_WALK_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic           clk;
    logic           reset;
    logic           ITLBMiss, DTLBMiss, TLBFlush;
    logic [VA-1:0]  ITLBVAdr, DTLBVAdr, WalkVAdr;
    logic           WalkReq, WalkAck, WalkDone, WalkFault;
    logic [PTE-1:0] WalkPTE, TLBPTE;
    logic           ITLBWrite, DTLBWrite, ITLBFault, DTLBFault, Busy;

    tlb_walk_arbiter #(.VA_BITS(VA), .PTE_BITS(PTE)) dut (
        .clk       (clk),
        .reset     (reset),
        .ITLBMiss  (ITLBMiss),
        .ITLBVAdr  (ITLBVAdr),
        .DTLBMiss  (DTLBMiss),
        .DTLBVAdr  (DTLBVAdr),
        .TLBFlush  (TLBFlush),
        .WalkReq   (WalkReq),
        .WalkVAdr  (WalkVAdr),
        .WalkAck   (WalkAck),
        .WalkDone  (WalkDone),
        .WalkFault (WalkFault),
        .WalkPTE   (WalkPTE),
        .ITLBWrite (ITLBWrite),
        .DTLBWrite (DTLBWrite),
        .TLBPTE    (TLBPTE),
        .ITLBFault (ITLBFault),
        .DTLBFault (DTLBFault),
        .Busy      (Busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors;
    int checks;

    // Reference model: where the single walk slot is in its life and what it carries.
    int             m_phase;
    bit             m_for_itlb, m_drop, m_fault, m_last_itlb;
    logic [VA-1:0]  m_vadr;
    logic [PTE-1:0] m_pte;
    bit             exp_i_resp, exp_d_resp;

    bit             w_busy;
    int             w_cnt;

    task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_phase     = 0;
        m_for_itlb  = 1'b0;
        m_drop      = 1'b0;
        m_fault     = 1'b0;
        m_last_itlb = 1'b1;
        m_vadr      = '0;
        m_pte       = '0;
        exp_i_resp  = 1'b0;
        exp_d_resp  = 1'b0;
        w_busy      = 1'b0;
        w_cnt       = 0;
    endtask

    task automatic model_compare();
        bit deliver;
        deliver    = (m_phase == 3) && !m_drop && !TLBFlush;
        exp_i_resp = deliver && m_for_itlb;
        exp_d_resp = deliver && !m_for_itlb;
        check_output("busy", Busy, m_phase != 0);
        check_output("walk_req", WalkReq, m_phase == 1);
        check_output("walk_vadr", WalkVAdr, m_vadr);
        check_output("tlb_pte", TLBPTE, m_pte);
        check_output("itlb_write", ITLBWrite, exp_i_resp && !m_fault);
        check_output("dtlb_write", DTLBWrite, exp_d_resp && !m_fault);
        check_output("itlb_fault", ITLBFault, exp_i_resp && m_fault);
        check_output("dtlb_fault", DTLBFault, exp_d_resp && m_fault);
    endtask

    task automatic model_advance();
        bit pick_i;
        case (m_phase)
            0: begin
                if ((ITLBMiss || DTLBMiss) && !TLBFlush) begin
                    if (ITLBMiss && DTLBMiss) pick_i = RR ? !m_last_itlb : 1'b0;
                    else                      pick_i = ITLBMiss;
                    m_for_itlb  = pick_i;
                    m_last_itlb = pick_i;
                    m_vadr      = pick_i ? ITLBVAdr : DTLBVAdr;
                    m_phase     = 1;
                end
            end
            1: begin
                if (WalkAck) begin
                    m_phase = 2;
                    m_drop  = TLBFlush;
                end else if (TLBFlush) begin
                    m_phase = 0;
                end
            end
            2: begin
                if (TLBFlush) m_drop = 1'b1;
                if (WalkDone) begin
                    m_pte   = WalkPTE;
                    m_fault = WalkFault;
                    m_phase = 3;
                end
            end
            default: begin
                m_phase = 0;
                m_drop  = 1'b0;
            end
        endcase
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        TLBFlush  = 1'b0;
        WalkAck   = 1'b0;
        WalkDone  = 1'b0;
        WalkFault = 1'b0;
    endtask

    task automatic settle();
        @(negedge clk);
        model_compare();
        if (!reset) model_reset();
        else        model_advance();
    endtask

    task automatic idle_cycles(input int n);
        for (int k = 0; k < n; k++) begin
            tick();
            settle();
        end
    endtask

    // Both sides miss together; the first winner is given, the loser must follow.
    task automatic pair_test(input bit exp_itlb_first);
        logic [VA-1:0] ia, da;
        ia = 39'h11_2233_4000;
        da = 39'h55_6677_8000;
        tick(); ITLBMiss = 1'b1; DTLBMiss = 1'b1; ITLBVAdr = ia; DTLBVAdr = da; settle();
        tick(); settle();
        check_output("pair_first_vadr", WalkVAdr, exp_itlb_first ? ia : da);
        tick(); WalkAck = 1'b1; settle();
        tick(); WalkDone = 1'b1; WalkPTE = 64'hAAAA_0001; settle();
        tick(); settle();
        check_output("pair_first_iwrite", ITLBWrite, exp_itlb_first);
        check_output("pair_first_dwrite", DTLBWrite, !exp_itlb_first);
        tick(); if (exp_itlb_first) ITLBMiss = 1'b0; else DTLBMiss = 1'b0; settle();
        tick(); settle();
        check_output("pair_second_req", WalkReq, 1);
        check_output("pair_second_vadr", WalkVAdr, exp_itlb_first ? da : ia);
        tick(); WalkAck = 1'b1; settle();
        tick(); WalkDone = 1'b1; WalkPTE = 64'hBBBB_0002; settle();
        tick(); settle();
        check_output("pair_second_iwrite", ITLBWrite, !exp_itlb_first);
        check_output("pair_second_pte", TLBPTE, 64'hBBBB_0002);
        tick(); ITLBMiss = 1'b0; DTLBMiss = 1'b0; settle();
    endtask

    task automatic apply_stimulus();
        logic [63:0] r;
        if (ITLBMiss && (exp_i_resp || $urandom_range(0, 63) == 0)) begin
            ITLBMiss = 1'b0;
        end else if (!ITLBMiss && $urandom_range(0, 3) == 0) begin
            r = {$urandom(), $urandom()};
            ITLBMiss = 1'b1;
            ITLBVAdr = r[VA-1:0];
        end
        if (DTLBMiss && (exp_d_resp || $urandom_range(0, 63) == 0)) begin
            DTLBMiss = 1'b0;
        end else if (!DTLBMiss && $urandom_range(0, 3) == 0) begin
            r = {$urandom(), $urandom()};
            DTLBMiss = 1'b1;
            DTLBVAdr = r[VA-1:0];
        end
        TLBFlush = ($urandom_range(0, 19) == 0);
        if (w_busy) begin
            if (w_cnt == 0) begin
                WalkDone  = 1'b1;
                WalkFault = ($urandom_range(0, 3) == 0);
                WalkPTE   = {$urandom(), $urandom()};
                w_busy    = 1'b0;
            end else begin
                w_cnt--;
            end
        end else if (m_phase == 1 && $urandom_range(0, 1) == 1) begin
            WalkAck = 1'b1;
            w_busy  = 1'b1;
            w_cnt   = $urandom_range(0, 4);
        end else if (m_phase != 2 && $urandom_range(0, 31) == 0) begin
            WalkDone = 1'b1;
            WalkPTE  = {$urandom(), $urandom()};
        end
        if (!WalkDone && $urandom_range(0, 15) == 0) WalkFault = 1'b1;
    endtask

    initial begin
        errors = 0;
        checks = 0;
        reset = 1'b0;
        ITLBMiss = 1'b0; DTLBMiss = 1'b0; TLBFlush = 1'b0;
        ITLBVAdr = '0; DTLBVAdr = '0;
        WalkAck = 1'b0; WalkDone = 1'b0; WalkFault = 1'b0; WalkPTE = '0;
        model_reset();

        #12;
        check_output("reset_busy", Busy, 0);
        check_output("reset_walkreq", WalkReq, 0);
        check_output("reset_vadr", WalkVAdr, 0);
        check_output("reset_pte", TLBPTE, 0);
        check_output("reset_strobes", {ITLBWrite, DTLBWrite, ITLBFault, DTLBFault}, 0);
        @(negedge clk);
        reset = 1'b1;

        pair_test(1'b0);

        // Lone DTLB walk with exact cycle timing.
        tick(); DTLBMiss = 1'b1; DTLBVAdr = 39'h12_3456_7000; settle();
        check_output("t1_c0_req", WalkReq, 0);
        tick(); settle();
        check_output("t1_c1_req", WalkReq, 1);
        check_output("t1_c1_vadr", WalkVAdr, 39'h12_3456_7000);
        tick(); WalkAck = 1'b1; settle();
        check_output("t1_c2_req", WalkReq, 1);
        tick(); settle();
        check_output("t1_c3_req", WalkReq, 0);
        check_output("t1_c3_busy", Busy, 1);
        idle_cycles(2);
        tick(); WalkDone = 1'b1; WalkPTE = 64'h2000_00CF; settle();
        check_output("t1_c6_dwrite", DTLBWrite, 0);
        tick(); settle();
        check_output("t1_c7_dwrite", DTLBWrite, 1);
        check_output("t1_c7_pte", TLBPTE, 64'h2000_00CF);
        check_output("t1_c7_iwrite", ITLBWrite, 0);
        tick(); DTLBMiss = 1'b0; settle();
        check_output("t1_c8_busy", Busy, 0);
        check_output("t1_c8_dwrite", DTLBWrite, 0);

        pair_test(RR);

        // ITLB walk ending in a page fault.
        tick(); ITLBMiss = 1'b1; ITLBVAdr = 39'h00_0000_F000; settle();
        tick(); settle();
        tick(); WalkAck = 1'b1; settle();
        tick(); WalkDone = 1'b1; WalkFault = 1'b1; WalkPTE = 64'h0; settle();
        tick(); settle();
        check_output("t3_ifault", ITLBFault, 1);
        check_output("t3_iwrite", ITLBWrite, 0);
        tick(); ITLBMiss = 1'b0; settle();
        check_output("t3_busy_after", Busy, 0);
        check_output("t3_ifault_after", ITLBFault, 0);

        // Flush while waiting: result discarded, held miss gets a fresh walk.
        tick(); DTLBMiss = 1'b1; DTLBVAdr = 39'h7F_0000_1000; settle();
        tick(); settle();
        tick(); WalkAck = 1'b1; settle();
        tick(); TLBFlush = 1'b1; settle();
        tick(); WalkDone = 1'b1; WalkPTE = 64'hDEAD_BEEF; settle();
        tick(); settle();
        check_output("t4_no_write", DTLBWrite, 0);
        check_output("t4_no_fault", DTLBFault, 0);
        tick(); settle();
        check_output("t4_idle", Busy, 0);
        tick(); settle();
        check_output("t4_fresh_req", WalkReq, 1);
        tick(); WalkAck = 1'b1; settle();
        tick(); WalkDone = 1'b1; WalkPTE = 64'h1234_5678; settle();
        tick(); settle();
        check_output("t4_fresh_write", DTLBWrite, 1);
        tick(); DTLBMiss = 1'b0; settle();

        // Flush before ack abandons the request.
        tick(); ITLBMiss = 1'b1; ITLBVAdr = 39'h01_0000_2000; settle();
        tick(); TLBFlush = 1'b1; settle();
        check_output("t5_req_during", WalkReq, 1);
        tick(); ITLBMiss = 1'b0; settle();
        check_output("t5_req_after", WalkReq, 0);
        check_output("t5_busy_after", Busy, 0);
        tick(); WalkAck = 1'b1; settle();
        tick(); settle();
        check_output("t5_late_ack", Busy, 0);

        // Async reset while waiting, then a stray completion.
        tick(); DTLBMiss = 1'b1; DTLBVAdr = 39'h02_0000_3000; settle();
        tick(); settle();
        tick(); WalkAck = 1'b1; settle();
        tick(); settle();
        #1 reset = 1'b0;
        #1;
        check_output("t6_busy", Busy, 0);
        check_output("t6_vadr", WalkVAdr, 0);
        check_output("t6_pte", TLBPTE, 0);
        check_output("t6_walkreq", WalkReq, 0);
        model_reset();
        DTLBMiss = 1'b0;
        tick(); settle();
        #2 reset = 1'b1;
        tick(); WalkDone = 1'b1; WalkPTE = 64'h5555_AAAA; settle();
        tick(); settle();
        check_output("t6_stray_busy", Busy, 0);
        check_output("t6_stray_pte", TLBPTE, 0);
        check_output("t6_stray_write", DTLBWrite, 0);

        for (int c = 0; c < 3000; c++) begin
            tick();
            apply_stimulus();
            settle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
